vga_pixel_writer: RTL

//  Downstream consumer of the MiniAlu VGA instruction (COLOR, col reg, row reg).

---
 rtl/vga_pixel_writer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_writer.sv
// vga_pixel_writer: buffers CPU pixel writes, range-checks them, writes the framebuffer; also sweeps a full-screen clear.
// Latency: a request taken at edge k into an empty FIFO with a free output register shows oFbWe=1 after edge k+1.
// Backpressure: iFbReady low holds the output register; the FIFO then fills and oStall drops further requests.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-low reset
//   iWrEn/iColor/iCol/iRow  pixel request (one-cycle valid, ignored while oStall)
//   iClear/iClearColor    full-screen clear request and its color
//   iFbReady              framebuffer accepts the presented write this cycle
//   oStall                CPU must hold (FIFO full, clear pending or clear running)
//   oFbWe/oFbAddr/oFbData framebuffer write port (valid/ready, held while not ready)
//   oClipCount            saturating count of out-of-range requests dropped

// Small generic synchronous FIFO: head data is visible combinationally, pop advances it.
// Latency: a pushed entry is at the head one edge after the push when the FIFO was empty.
// Backpressure: the caller must not push when full nor pop when empty; no internal guarding.
module vga_pixel_writer_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

module vga_pixel_writer #(
  parameter int H_RES      = 256,
  parameter int V_RES      = 384,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iWrEn,
  input  logic [2:0]        iColor,
  input  logic [15:0]       iCol,
  input  logic [15:0]       iRow,
  input  logic              iClear,
  input  logic [2:0]        iClearColor,
  input  logic              iFbReady,
  output logic              oStall,
  output logic              oFbWe,
  output logic [ADDR_W-1:0] oFbAddr,
  output logic [2:0]        oFbData,
  output logic [15:0]       oClipCount
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 3 + 16 + 16;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]       H_LIM     = 16'(H_RES);
  localparam logic [15:0]       V_LIM     = 16'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  // Control and output registers
  logic [1:0]        r_state;
  logic              r_clear_pending;
  logic [2:0]        r_clear_color;
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [2:0]        r_fb_data;
  logic [15:0]       r_clip_cnt;

  // Datapath / control wires
  logic [ENT_W-1:0]  w_push_dat;
  logic [ENT_W-1:0]  w_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_head_color;
  logic [15:0]       w_head_col;
  logic [15:0]       w_head_row;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_lin_addr;
  logic              w_in_clear;
  logic              w_out_load;
  logic              w_clear_accept;
  logic              w_clear_start;
  logic              w_last_accepted;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  assign w_push_dat = {iColor, iCol, iRow};

  vga_pixel_writer_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk      (Clock),
    .i_rst_n    (Reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_fifo_count)
  );

  assign w_fifo_empty = (w_fifo_count == '0);
  assign w_fifo_full  = (w_fifo_count == FULL_CNT);

  assign w_head_color = w_head[34:32];
  assign w_head_col   = w_head[31:16];
  assign w_head_row   = w_head[15:0];

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  // Any encoding other than CLEAR behaves as RUN; the state register is forced
  // back to RUN on the next edge.
  assign w_in_clear = (r_state == ST_CLEAR);

  assign oStall = w_fifo_full | r_clear_pending | w_in_clear;

  // The output register may take a new value when it is empty or its current
  // write is being accepted this cycle.
  assign w_out_load = !r_fb_we || iFbReady;

  assign w_push = iWrEn && !oStall;
  assign w_pop  = !w_in_clear && w_out_load && !w_fifo_empty;

  // ---------------------------------------------------------------------------
  // Range check and linear address
  // ---------------------------------------------------------------------------
  // Range check on the full 16-bit operands. The address arithmetic is done
  // modulo 2^ADDR_W: for in-range requests this equals the low ADDR_W bits of
  // the full 16x16 product, and out-of-range results are never used.
  assign w_in_range = (w_head_col < H_LIM) && (w_head_row < V_LIM);
  assign w_lin_addr = ADDR_W'(w_head_row) * H_RES_A + ADDR_W'(w_head_col);

  // ---------------------------------------------------------------------------
  // Clear sequencing
  // ---------------------------------------------------------------------------
  // A clear is only latched from RUN with nothing already pending.
  assign w_clear_accept = iClear && !w_in_clear && !r_clear_pending;

  // The sweep starts once every earlier request has left: FIFO empty and the
  // output register idle. The first sweep address is loaded at that same edge.
  assign w_clear_start = !w_in_clear && r_clear_pending && w_fifo_empty && !r_fb_we;

  assign w_last_accepted = w_in_clear && r_fb_we && iFbReady && (r_fb_addr == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // State, clear bookkeeping, output register, clip counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state         <= ST_RUN;
      r_clear_pending <= 1'b0;
      r_clear_color   <= 3'd0;
      r_fb_we         <= 1'b0;
      r_fb_addr       <= '0;
      r_fb_data       <= 3'd0;
      r_clip_cnt      <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_clear_start) begin
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (w_last_accepted) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase

      if (w_clear_accept) begin
        r_clear_pending <= 1'b1;
        r_clear_color   <= iClearColor;
      end else if (w_last_accepted) begin
        r_clear_pending <= 1'b0;
      end

      if (w_out_load) begin
        if (w_in_clear) begin
          // In CLEAR the register always holds a sweep write; loading means
          // that write was accepted, so advance or finish.
          if (w_last_accepted) begin
            r_fb_we <= 1'b0;
          end else if (r_fb_we) begin
            r_fb_addr <= r_fb_addr + ADDR_W'(1);
          end
        end else if (w_clear_start) begin
          r_fb_we   <= 1'b1;
          r_fb_addr <= '0;
          r_fb_data <= r_clear_color;
        end else if (w_pop && w_in_range) begin
          r_fb_we   <= 1'b1;
          r_fb_addr <= w_lin_addr;
          r_fb_data <= w_head_color;
        end else begin
          // Nothing to present, or the popped request was clipped.
          r_fb_we <= 1'b0;
        end
      end

      if (w_pop && !w_in_range && (r_clip_cnt != 16'hFFFF)) begin
        r_clip_cnt <= r_clip_cnt + 16'd1;
      end
    end
  end

  assign oFbWe      = r_fb_we;
  assign oFbAddr    = r_fb_addr;
  assign oFbData    = r_fb_data;
  assign oClipCount = r_clip_cnt;

endmodule
